// File: rtl/keypad_scan.sv
// 3x3 keypad row scanner with per-key debounce and one-cycle press pulses.
// Optional auto-repeat of a single held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan #(
    parameter int DEBOUNCE      = 4,
    parameter int REPEAT_FRAMES = 64
) (
    input  logic       scan_clk,
    input  logic       rst,
    input  logic [2:0] col_n,
    output logic [2:0] row_n,
    output logic [8:0] btns,
    output logic [8:0] held,
    output logic       key_valid,
    output logic [3:0] key_code
);

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);

    if (DEBOUNCE < 1 || DEBOUNCE > 15 || REPEAT_FRAMES < 2 || REPEAT_FRAMES > 255) begin : g_bad_params
        $error("keypad_scan: DEBOUNCE or REPEAT_FRAMES out of range");
    end

    logic [2:0] p_q, p_d;
    logic       run_q;
    logic [2:0] row_n_q, row_n_d;
    logic [8:0] held_q, held_d;
    logic [8:0] btns_q, btns_d;
    logic [8:0] press;
    logic [3:0] cnt_q [9];
    logic [3:0] cnt_d [9];
    logic       sample_en;
    logic [1:0] row_sel;

    // run_q holds p at 0 for one cycle after reset so row R1 is driven before it is sampled
    always_comb begin
        p_d = 3'd0;
        if (run_q) begin
            p_d = (p_q == 3'd5) ? 3'd0 : p_q + 3'd1;
        end
        case (p_d)
            3'd0:    row_n_d = 3'b110;
            3'd2:    row_n_d = 3'b101;
            3'd4:    row_n_d = 3'b011;
            default: row_n_d = 3'b111;
        endcase
    end

    assign sample_en = run_q && !p_q[0];
    assign row_sel   = p_q[2:1];

    for (genvar gi = 0; gi < 9; gi++) begin : g_key
        localparam int R = gi / 3;
        localparam int C = gi % 3;
        logic upd;
        logic raw;
        assign upd         = sample_en && (row_sel == 2'(R));
        assign raw         = ~col_n[C];
        assign held_d[gi]  = (upd && raw != held_q[gi] && cnt_q[gi] == DB_LAST) ? ~held_q[gi] : held_q[gi];
        assign cnt_d[gi]   = !upd ? cnt_q[gi] :
                             (raw == held_q[gi] || cnt_q[gi] == DB_LAST) ? 4'd0 : cnt_q[gi] + 4'd1;
    end

    assign press = held_d & ~held_q;

`ifdef KEYPAD_REPEAT_EN
    localparam logic [7:0] REP_LAST = 8'(REPEAT_FRAMES - 1);

    logic [7:0] rep_q, rep_d;
    logic [8:0] row_mask;
    logic       one_held;
    logic       rep_pulse;

    always_comb begin
        case (row_sel)
            2'd0:    row_mask = 9'h007;
            2'd1:    row_mask = 9'h038;
            default: row_mask = 9'h1C0;
        endcase
        one_held  = $onehot(held_q);
        rep_d     = rep_q;
        rep_pulse = 1'b0;
        if (!one_held) begin
            rep_d = 8'd0;
        end else if (sample_en && |(held_q & held_d & row_mask)) begin
            // one tick per frame, taken in the held key's own sampling phase
            if (rep_q == REP_LAST) begin
                rep_pulse = 1'b1;
                rep_d     = 8'd0;
            end else begin
                rep_d = rep_q + 8'd1;
            end
        end
        btns_d = press | (rep_pulse ? (held_q & row_mask) : 9'h000);
    end

    always_ff @(posedge scan_clk) begin
        if (rst) begin
            rep_q <= 8'd0;
        end else begin
            rep_q <= rep_d;
        end
    end
`else
    assign btns_d = press;
`endif

    always_ff @(posedge scan_clk) begin
        if (rst) begin
            p_q     <= 3'd0;
            run_q   <= 1'b0;
            row_n_q <= 3'b111;
            held_q  <= 9'h000;
            btns_q  <= 9'h000;
            for (int i = 0; i < 9; i++) begin
                cnt_q[i] <= 4'd0;
            end
        end else begin
            p_q     <= p_d;
            run_q   <= 1'b1;
            row_n_q <= row_n_d;
            held_q  <= held_d;
            btns_q  <= btns_d;
            for (int i = 0; i < 9; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // lowest column wins when several keys of one row settle together
    always_comb begin
        key_code = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (btns_q[i]) begin
                key_code = 4'(i);
            end
        end
    end

    assign key_valid = |btns_q;
    assign row_n     = row_n_q;
    assign btns      = btns_q;
    assign held      = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized scoreboard bench for keypad_scan: a frame-level key model predicts
// row drives, debounced state and press pulses; a monitor compares every cycle.
module tb_keypad_scan;

    localparam int DB = 4;
    localparam int RF = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] col_n;
    logic [2:0] row_n;
    logic [8:0] btns;
    logic [8:0] held;
    logic       key_valid;
    logic [3:0] key_code;

    logic [8:0] pressed = 9'h000;

    keypad_scan #(.DEBOUNCE(DB), .REPEAT_FRAMES(RF)) dut (
        .scan_clk (clk),
        .rst      (rst),
        .col_n    (col_n),
        .row_n    (row_n),
        .btns     (btns),
        .held     (held),
        .key_valid(key_valid),
        .key_code (key_code)
    );

    always #5 clk = ~clk;

    // Physical matrix: a column is pulled low by any pressed key whose row is driven.
    always_comb begin
        for (int c = 0; c < 3; c++) begin
            col_n[c] = ~((pressed[c] & ~row_n[0]) | (pressed[3 + c] & ~row_n[1]) | (pressed[6 + c] & ~row_n[2]));
        end
    end

    typedef struct {
        int         cyc;
        logic [8:0] mask;
    } ev_t;
    ev_t exp_q[$];

    int         checks = 0;
    int         errors = 0;
    int         mc = 0;          // cycles since reset release; phase = (mc-1)%6 for mc>=1
    logic [8:0] mheld = 9'h000;
    int         mcnt [9];
    int         mrep = 0;
    int         first_cyc = -1;
    logic [8:0] first_btns = 9'h000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, mc);
        end
    endtask

    // Reference model: per-key frame samples of the true key state.
    initial begin
        for (int i = 0; i < 9; i++) mcnt[i] = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                mc    = 0;
                mheld = 9'h000;
                mrep  = 0;
                for (int i = 0; i < 9; i++) mcnt[i] = 0;
            end else begin
                logic [8:0] pm;
                logic [8:0] prev;
                pm   = 9'h000;
                prev = mheld;
                if (mc >= 1 && ((mc - 1) % 6) % 2 == 0) begin
                    int r;
                    r = ((mc - 1) % 6) / 2;
                    for (int c = 0; c < 3; c++) begin
                        int k;
                        k = 3 * r + c;
                        if (pressed[k] == mheld[k]) begin
                            mcnt[k] = 0;
                        end else if (mcnt[k] == DB - 1) begin
                            mheld[k] = ~mheld[k];
                            mcnt[k]  = 0;
                            if (mheld[k]) pm[k] = 1'b1;
                        end else begin
                            mcnt[k]++;
                        end
                    end
`ifdef KEYPAD_REPEAT_EN
                    if ($countones(prev) == 1 && ((prev >> (3 * r)) & 9'h007) != 0 && (prev & mheld) != 0) begin
                        mrep++;
                        if (mrep == RF) begin
                            pm   = pm | prev;
                            mrep = 0;
                        end
                    end
`endif
                end
`ifdef KEYPAD_REPEAT_EN
                if ($countones(prev) != 1) mrep = 0;
`endif
                mc++;
                if (pm != 9'h000) exp_q.push_back('{cyc: mc, mask: pm});
            end
        end
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    initial begin
        forever begin
            logic [2:0] er;
            logic [8:0] eb;
            int         ec;
            @(negedge clk);
            if (mc == 0) begin
                er = 3'b111;
            end else begin
                case ((mc - 1) % 6)
                    0:       er = 3'b110;
                    2:       er = 3'b101;
                    4:       er = 3'b011;
                    default: er = 3'b111;
                endcase
            end
            chk("row_n", 32'(row_n), 32'(er));
            chk("held", 32'(held), 32'(mheld));
            eb = 9'h000;
            if (exp_q.size() > 0 && exp_q[0].cyc == mc) begin
                eb = exp_q[0].mask;
                void'(exp_q.pop_front());
            end
            chk("btns", 32'(btns), 32'(eb));
            chk("key_valid", 32'(key_valid), 32'(eb != 9'h000));
            if (eb != 9'h000) begin
                ec = 0;
                for (int i = 8; i >= 0; i--) if (eb[i]) ec = i;
                chk("key_code", 32'(key_code), 32'(ec));
            end
            if (mc == 0) chk("key_code_rst", 32'(key_code), 32'd0);
            if (key_valid && first_cyc < 0) begin
                first_cyc  = mc;
                first_btns = btns;
            end
        end
    end

    task automatic hold(input logic [8:0] pat, input int n);
        pressed = pat;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        pressed = 9'h000;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        first_cyc = -1;
    endtask

    initial begin
        @(negedge clk);
        // reset and idle scan
        do_reset();
        hold(9'h000, 40);
        chk("idle_no_pulse", 32'(first_cyc), 32'hFFFF_FFFF);

        // basic press R3/C2: pulse at p=5 of frame 3
        do_reset();
        hold(9'h080, 80);
        chk("press_cycle", 32'(first_cyc), 32'd24);
        chk("press_btns", 32'(first_btns), 32'h080);

        // bounce on R1/C1
        do_reset();
        hold(9'h001, 18);
        hold(9'h000, 6);
        hold(9'h001, 40);
        chk("bounce_cycle", 32'(first_cyc), 32'd44);
        chk("bounce_btns", 32'(first_btns), 32'h001);

        // two keys in row 2 settle together
        do_reset();
        hold(9'h028, 40);
        chk("row2_cycle", 32'(first_cyc), 32'd22);
        chk("row2_btns", 32'(first_btns), 32'h028);

        // reset while a key is held, then release of reset re-debounces it
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        hold(9'h028, 40);

`ifdef KEYPAD_REPEAT_EN
        do_reset();
        hold(9'h002, 220);
        hold(9'h012, 120);
`endif

        // randomized key patterns, including short glitches and stray resets
        do_reset();
        repeat (60) begin
            logic [8:0] pat;
            pat = 9'($urandom) & 9'($urandom) & 9'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            hold(pat, $urandom_range(1, 60));
        end
        hold(9'h000, 60);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
